conv_itlv: RTL and testbench
============================

Name: conv_itlv

Overview:
- DVB-C/T (Forney) convolutional interleaver, I=12 branches, M=17 cells per branch step. It is the transmit-side counterpart of `deint`.
- Branch j delays its symbols by j*M branch-visits. Branch 0 is a pure register.
- Sits between the RS(204,188) encoder and the modulator. Uses the same sym_ena/sym_din to sym_vld/sym_dout strobe interface as `deint`.
- `deint(conv_itlv(x))` returns x delayed by I*(I-1)*M = 2244 symbols.

Parameters:
- I, 12, number of branches (commutator positions)
- M, 17, delay-cell increment per branch, in symbols
- W, 8, symbol width in bits

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high (one clock; reset is synchronous and active-high)
- sym_ena  in  1  input symbol strobe, any duty cycle up to 1/cycle
- sym_din  in  W  input symbol, valid when sym_ena=1
- sym_vld  out  1  output symbol strobe
- sym_dout  out  W  interleaved symbol, valid when sym_vld=1

Behaviour:
- Reset values:
  - sym_vld=0, sym_dout=0.
  - Commutator br=0.
  - All branch pointers p_j=0.
  - All branch wrapped flags wr_j=0.
- Commutator:
  - On each cycle with sym_ena=1, br advances (br==I-1 -> 0).
  - No other event moves br. With 204=12*17, packet sync bytes always land on branch 0.
- Latency:
  - sym_ena at cycle t gives sym_vld=1 at cycle t+1, exactly one output per input.
  - sym_vld=0 on every other cycle; sym_dout holds its last value when sym_vld=0.
- Branch 0: sym_dout(t+1)=sym_din(t).
- Branch j>=1 storage:
  - Circular buffer of j*M entries in one shared RAM, DEPTH=M*I*(I-1)/2=1122.
  - Base address B_j=M*j*(j-1)/2.
  - Access address A=B_j+p_j. Read-first: the old content goes to the output and sym_din is written in the same cycle.
  - Then p_j increments; p_j==j*M-1 wraps to 0 and sets wr_j=1.
- Fill rule:
  - While wr_j=0, branch j outputs 0 regardless of RAM contents, so the RAM needs no clearing.
  - Once wr_j=1, branch j outputs the stored symbol.
- Input/output relation: input symbol index k (0-based, counted from reset) appears at output index k+I*M*(k mod I).
- Back-to-back sym_ena: supported every cycle. Read/write address and branch select are registered alongside the RAM read so the output mux matches.
- Address arithmetic:
  - RAM address width is clog2(DEPTH).
  - p_j width is clog2((I-1)*M).
  - B_j comes from a constant function or table, never a runtime multiply.
- Reset mid-stream:
  - br, p_j and wr_j clear.
  - The next output is sym_vld=0 unless sym_ena is sampled in the reset cycle, which is ignored.
  - Subsequent outputs restart the zero-fill phase.
- Reset and sym_ena in the same cycle: reset wins and the symbol is dropped.

Decomposition:
- Package conv_itlv_pkg holds:
  - I, M, W defaults
  - DEPTH
  - address and pointer widths
  - constant function branch_base(j)
  - branch index type
- Sub-module itlv_ram: single-port, synchronous read-first RAM, DEPTH x W. No reset on the array.
- Pointer and wrapped-flag bank and commutator stay in conv_itlv.

Test Plan:
- Reset then 12 strobes with din=1..12 at 1/3 duty -> outputs 1,0,0,... (11 zeros); sym_vld one cycle after each sym_ena.
- Continuous ena every cycle with din=k mod 256 for 3000 symbols -> output index n equals input n-204*(n mod 12) when that index is >=0, else 0. Check n=204: branch 0, value 204 mod 256=204. Check n=217: branch 1, input index 13.
- Boundary of branch 11 -> first nonzero on branch 11 at output index 11+2244=2255, carrying input index 11.
- Loopback into `deint` with the 204-byte-packet stream used for `deint` verification (sync 0x47 first) -> deint output equals the original stream delayed 2244 symbols, sync bytes intact.
- Assert rst at input symbol 500, then resume -> outputs restart the zero-fill pattern identical to the first run; no stale RAM data appears.
- Randomly gapped sym_ena (0-5 idle cycles) -> output sequence identical to the continuous case; the number of sym_vld pulses equals the number of sym_ena pulses.

Source files
------------

// File: rtl/conv_itlv_pkg.sv
// Shared constants, types and address helpers for the convolutional interleaver.
package conv_itlv_pkg;

  localparam int I = 12;  // commutator positions
  localparam int M = 17;  // cell increment per branch
  localparam int W = 8;   // symbol width

  // Total cells for branches 1..I-1 (branch 0 has no storage)
  localparam int DEPTH  = M * I * (I - 1) / 2;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = $clog2((I - 1) * M);
  localparam int BR_W   = $clog2(I);

  typedef logic [BR_W-1:0] br_t;

  // Start address of branch j's circular buffer; only ever evaluated on constants
  function automatic int branch_base(input int j);
    return M * j * (j - 1) / 2;
  endfunction

endpackage

// File: rtl/itlv_ram.sv
// Single-port synchronous RAM, read-first: a write returns the previous content.
module itlv_ram
  import conv_itlv_pkg::*;
#(
  parameter int DEPTH_P = DEPTH,
  parameter int AW      = ADDR_W,
  parameter int DW      = W
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [DEPTH_P];
  logic [DW-1:0] r_rdata;

  // Read old content and overwrite in the same access; rdata holds when idle
  always_ff @(posedge clk) begin
    if (en) begin
      r_rdata     <= r_mem[addr];
      r_mem[addr] <= wdata;
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/conv_itlv.sv
// Forney convolutional interleaver: branch j delays its symbols by j*M branch visits.
module conv_itlv
  import conv_itlv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         sym_ena,
  input  logic [W-1:0] sym_din,
  output logic         sym_vld,
  output logic [W-1:0] sym_dout
);

  br_t               r_br;        // commutator position
  logic [PTR_W-1:0]  w_ptr  [I];  // per-branch buffer pointer
  logic              w_wr   [I];  // per-branch "buffer has wrapped" flag
  logic [ADDR_W-1:0] w_base [I];  // constant base address per branch

  logic              w_take;      // a symbol is accepted this cycle
  logic              w_ram_en;
  logic [ADDR_W-1:0] w_addr;
  logic [W-1:0]      w_rdata;

  // Output-side state, captured together with the RAM read
  logic              r_vld;
  br_t               r_sel_br;
  logic              r_sel_wr;
  logic [W-1:0]      r_din0;

  // Reset wins over a coincident strobe, so the symbol is simply dropped
  assign w_take   = sym_ena && !rst;
  assign w_ram_en = w_take && (r_br != br_t'(0));
  assign w_addr   = w_base[r_br] + ADDR_W'(w_ptr[r_br]);

  genvar gi;
  generate
    for (gi = 0; gi < I; gi++) begin : g_branch
      assign w_base[gi] = ADDR_W'(branch_base(gi));
      if (gi == 0) begin : g_b0
        // Branch 0 is a plain register and never touches the RAM
        assign w_ptr[gi] = '0;
        assign w_wr[gi]  = 1'b1;
      end else begin : g_bj
        logic [PTR_W-1:0] r_ptr;
        logic             r_wr;
        // Advance this branch's pointer on each visit; first wrap ends zero-fill
        always_ff @(posedge clk) begin
          if (rst) begin
            r_ptr <= '0;
            r_wr  <= 1'b0;
          end else if (sym_ena && (r_br == br_t'(gi))) begin
            if (r_ptr == PTR_W'(gi * M - 1)) begin
              r_ptr <= '0;
              r_wr  <= 1'b1;
            end else begin
              r_ptr <= r_ptr + PTR_W'(1);
            end
          end
        end
        assign w_ptr[gi] = r_ptr;
        assign w_wr[gi]  = r_wr;
      end
    end
  endgenerate

  // Commutator steps once per accepted symbol
  always_ff @(posedge clk) begin
    if (rst) begin
      r_br <= '0;
    end else if (sym_ena) begin
      r_br <= (r_br == br_t'(I - 1)) ? br_t'(0) : r_br + br_t'(1);
    end
  end

  // Capture branch select, fill state and the branch-0 symbol alongside the RAM read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld    <= 1'b0;
      r_sel_br <= '0;
      r_sel_wr <= 1'b0;
      r_din0   <= '0;
    end else begin
      r_vld <= sym_ena;
      if (sym_ena) begin
        r_sel_br <= r_br;
        r_sel_wr <= w_wr[r_br];
        if (r_br == br_t'(0)) begin
          r_din0 <= sym_din;
        end
      end
    end
  end

  itlv_ram u_ram (
    .clk   (clk),
    .en    (w_ram_en),
    .addr  (w_addr),
    .wdata (sym_din),
    .rdata (w_rdata)
  );

  // All selects are registered and only change on a strobe, so the output holds when idle
  assign sym_vld  = r_vld;
  assign sym_dout = (r_sel_br == br_t'(0)) ? r_din0 :
                    (r_sel_wr ? w_rdata : '0);

endmodule

// File: tb/tb_conv_itlv.sv
// Directed bench for conv_itlv: fill pattern, continuous/gapped streams, loopback, reset.
module tb_conv_itlv;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sym_ena = 1'b0;
  logic [7:0] sym_din = 8'h00;
  logic       sym_vld;
  logic [7:0] sym_dout;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] cap [0:4095];
  int         cap_n = 0;

  conv_itlv dut (
    .clk      (clk),
    .rst      (rst),
    .sym_ena  (sym_ena),
    .sym_din  (sym_din),
    .sym_vld  (sym_vld),
    .sym_dout (sym_dout)
  );

  always #5 clk = ~clk;

  // Collect every valid output symbol
  always @(negedge clk) begin
    if (sym_vld && cap_n < 4096) begin
      cap[cap_n] = sym_dout;
      cap_n = cap_n + 1;
    end
  end

  // Expected interleaver output at index n for input stream din[k] = k mod 256
  function automatic logic [7:0] exp_itlv(input int n);
    int idx;
    idx = n - 204 * (n % 12);
    return (idx >= 0) ? idx[7:0] : 8'h00;
  endfunction

  // 204-byte packet stream, sync byte first
  function automatic logic [7:0] pkt(input int k);
    int v;
    v = (k * 7 + 3) & 255;
    return ((k % 204) == 0) ? 8'h47 : v[7:0];
  endfunction

  task automatic send(input logic [7:0] d);
    sym_ena = 1'b1;
    sym_din = d;
    @(posedge clk); #1;
    sym_ena = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sym_ena = 1'b0;
    idle(2);
    rst = 1'b0;
    cap_n = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (sym_vld !== 1'b0) begin
      n_err++; $display("FAIL reset_vld: got %0b want 0", sym_vld);
    end
    n_cmp++;
    if (sym_dout !== 8'h00) begin
      n_err++; $display("FAIL reset_dout: got %0d want 0", sym_dout);
    end
    $display("test_reset: done");
  endtask

  task automatic test_slow_fill();
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      send(8'(i));
      n_cmp++;
      if (sym_vld !== 1'b1) begin
        n_err++; $display("FAIL fill_latency[%0d]: vld %0b want 1", i, sym_vld);
      end
      idle(1);
      n_cmp++;
      if (sym_vld !== 1'b0) begin
        n_err++; $display("FAIL fill_gap_vld[%0d]: vld %0b want 0", i, sym_vld);
      end
      if (i == 1) begin
        n_cmp++;
        if (sym_dout !== 8'd1) begin
          n_err++; $display("FAIL fill_hold: dout %0d want 1", sym_dout);
        end
      end
      idle(1);
    end
    n_cmp++;
    if (cap_n !== 12) begin
      n_err++; $display("FAIL fill_count: got %0d want 12", cap_n);
    end
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (cap[i] !== ((i == 0) ? 8'd1 : 8'd0)) begin
        n_err++; $display("FAIL fill_out[%0d]: got %0d want %0d", i, cap[i], (i == 0) ? 1 : 0);
      end
    end
    $display("test_slow_fill: %0d outputs", cap_n);
  endtask

  task automatic test_continuous();
    do_reset();
    for (int k = 0; k < 3000; k++) send(8'(k));
    idle(2);
    n_cmp++;
    if (cap_n !== 3000) begin
      n_err++; $display("FAIL cont_count: got %0d want 3000", cap_n);
    end
    n_cmp++;
    if (cap[204] !== 8'd204) begin
      n_err++; $display("FAIL cont_n204: got %0d want 204", cap[204]);
    end
    n_cmp++;
    if (cap[217] !== 8'd13) begin
      n_err++; $display("FAIL cont_n217: got %0d want 13", cap[217]);
    end
    n_cmp++;
    if (cap[2243] !== 8'd0) begin
      n_err++; $display("FAIL br11_last_zero: got %0d want 0", cap[2243]);
    end
    n_cmp++;
    if (cap[2255] !== 8'd11) begin
      n_err++; $display("FAIL br11_first: got %0d want 11", cap[2255]);
    end
    for (int n = 0; n < 3000; n++) begin
      n_cmp++;
      if (cap[n] !== exp_itlv(n)) begin
        n_err++; $display("FAIL cont_out[%0d]: got %0d want %0d", n, cap[n], exp_itlv(n));
      end
    end
    $display("test_continuous: %0d outputs", cap_n);
  endtask

  task automatic test_loopback();
    int nsym;
    int m;
    logic [7:0] d;
    nsym = 2244 + 3 * 204;
    do_reset();
    for (int k = 0; k < nsym; k++) send(pkt(k));
    idle(2);
    n_cmp++;
    if (cap_n !== nsym) begin
      n_err++; $display("FAIL loop_count: got %0d want %0d", cap_n, nsym);
    end
    // Deinterleave offline: branch b delays by (I-1-b)*M visits
    for (int n = 2244; n < nsym; n++) begin
      m = n - 204 * (11 - (n % 12));
      d = (m >= 0) ? cap[m] : 8'h00;
      n_cmp++;
      if (d !== pkt(n - 2244)) begin
        n_err++; $display("FAIL loop_out[%0d]: got %0d want %0d", n, d, pkt(n - 2244));
      end
      if (((n - 2244) % 204) == 0) begin
        n_cmp++;
        if (d !== 8'h47) begin
          n_err++; $display("FAIL loop_sync[%0d]: got %0h want 47", n, d);
        end
      end
    end
    $display("test_loopback: %0d symbols", nsym);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 500; k++) send(8'(k));
    // Reset coincident with a strobe: symbol must be dropped
    rst = 1'b1;
    sym_ena = 1'b1;
    sym_din = 8'hAA;
    @(posedge clk); #1;
    rst = 1'b0;
    sym_ena = 1'b0;
    n_cmp++;
    if (sym_vld !== 1'b0) begin
      n_err++; $display("FAIL midrst_vld: got %0b want 0", sym_vld);
    end
    cap_n = 0;
    for (int k = 0; k < 300; k++) send(8'(k));
    idle(2);
    n_cmp++;
    if (cap_n !== 300) begin
      n_err++; $display("FAIL midrst_count: got %0d want 300", cap_n);
    end
    for (int n = 0; n < 300; n++) begin
      n_cmp++;
      if (cap[n] !== exp_itlv(n)) begin
        n_err++; $display("FAIL midrst_out[%0d]: got %0d want %0d", n, cap[n], exp_itlv(n));
      end
    end
    $display("test_reset_mid: %0d outputs", cap_n);
  endtask

  task automatic test_gapped();
    int n_ena;
    int gap;
    do_reset();
    n_ena = 0;
    for (int k = 0; k < 700; k++) begin
      send(8'(k));
      n_ena++;
      gap = int'($urandom_range(0, 5));
      idle(gap);
    end
    idle(2);
    n_cmp++;
    if (cap_n !== n_ena) begin
      n_err++; $display("FAIL gap_count: got %0d want %0d", cap_n, n_ena);
    end
    for (int n = 0; n < 700; n++) begin
      n_cmp++;
      if (cap[n] !== exp_itlv(n)) begin
        n_err++; $display("FAIL gap_out[%0d]: got %0d want %0d", n, cap[n], exp_itlv(n));
      end
    end
    $display("test_gapped: %0d strobes", n_ena);
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_slow_fill();
    test_continuous();
    test_loopback();
    test_reset_mid();
    test_gapped();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
